pb_port_hub: RTL and testbench

Parametrised I/O and interrupt hub for the KCPSM6 processor subsystem. It decodes `port_id` into output registers, registered input channels and a maskable edge-triggered interrupt controller, and drives the processor `in_port` and `interrupt` pins. It sits between the `picoblaze` wrapper and the MP3 datapath (LCD, SD/SPI, decoder, buttons), replacing per-design glue decoders.

---
 rtl/pb_port_hub_pkg.sv | 19 +
 rtl/pb_irq_ctrl.sv | 121 ++++++++++++
 rtl/pb_port_hub.sv | 115 +++++++++++
 tb/tb_pb_port_hub.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_port_hub_pkg.sv
// pb_port_hub shared constants: port offsets and IRQ FSM encoding.
// Optional timer is enabled by defining PB_PORT_HUB_TIMER_EN.
package pb_port_hub_pkg;

  localparam logic [5:0] OFS_OUT        = 6'h00;
  localparam logic [5:0] OFS_IN         = 6'h10;
  localparam logic [5:0] OFS_IRQ_STATUS = 6'h20;
  localparam logic [5:0] OFS_IRQ_MASK   = 6'h21;
  localparam logic [5:0] OFS_IRQ_CLEAR  = 6'h22;
  localparam logic [5:0] OFS_TIMER_LO   = 6'h23;
  localparam logic [5:0] OFS_TIMER_HI   = 6'h24;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ASSERT,
    IRQ_SERVICE
  } irq_state_e;

endpackage

// File: rtl/pb_irq_ctrl.sv
// Edge-triggered, maskable interrupt controller for pb_port_hub.
// Macro PB_PORT_HUB_TIMER_EN adds a 16-bit reload timer on pending[7].
module pb_irq_ctrl
  import pb_port_hub_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [7:0]         wdata,
  input  logic               wr_mask,
  input  logic               wr_clear,
  input  logic               wr_tlo,
  input  logic               wr_thi,
  input  logic               irq_ack,
  output logic [7:0]         pending,
  output logic [7:0]         mask,
  output logic [7:0]         timer_lo,
  output logic [7:0]         timer_hi,
  output logic               interrupt
);

  localparam logic [7:0] SRC_BITS = 8'((1 << NUM_IRQ) - 1);
`ifdef PB_PORT_HUB_TIMER_EN
  localparam logic [7:0] VALID = SRC_BITS | 8'h80;
`else
  localparam logic [7:0] VALID = SRC_BITS;
`endif

  logic [NUM_IRQ-1:0] src_d;
  logic               tick;
  logic [7:0]         set_bits;
  logic [7:0]         clr_bits;
  logic               active;
  irq_state_e         state, state_nxt;

  // Set is OR-ed after the clear so a same-cycle edge wins.
  assign set_bits = 8'(irq_src & ~src_d) | {tick, 7'b0};
  assign clr_bits = wr_clear ? wdata : 8'h00;
  assign active   = |(pending & mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_d   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      src_d   <= irq_src;
      pending <= ((pending & ~clr_bits) | set_bits) & VALID;
      if (wr_mask)
        mask <= wdata & VALID;
    end
  end

`ifdef PB_PORT_HUB_TIMER_EN
  logic [15:0] cnt;
  logic [15:0] reload;

  assign reload = {timer_hi, timer_lo};
  assign tick   = !wr_thi && (reload != 16'h0) && (cnt == 16'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_lo <= '0;
      timer_hi <= '0;
      cnt      <= '0;
    end else begin
      if (wr_tlo)
        timer_lo <= wdata;
      if (wr_thi)
        timer_hi <= wdata;
      if (wr_thi)
        cnt <= {wdata, timer_lo};
      else if (reload == 16'h0)
        cnt <= '0;
      else if (cnt == 16'h0)
        cnt <= reload;
      else
        cnt <= cnt - 16'h1;
    end
  end
`else
  logic unused_timer;
  assign unused_timer = ^{wr_tlo, wr_thi};
  assign tick         = 1'b0;
  assign timer_lo     = 8'h00;
  assign timer_hi     = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IRQ_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    interrupt = 1'b0;
    unique case (state)
      IRQ_IDLE: begin
        if (active)
          state_nxt = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        interrupt = 1'b1;
        if (irq_ack)
          state_nxt = IRQ_SERVICE;
        else if (!active)
          state_nxt = IRQ_IDLE;
      end
      IRQ_SERVICE: begin
        if (wr_clear)
          state_nxt = IRQ_IDLE;
      end
      default: state_nxt = IRQ_IDLE;
    endcase
  end

endmodule

// File: rtl/pb_port_hub.sv
// KCPSM6 port hub: address decode, output registers, read mux.
// Optional timer (pb_irq_ctrl) is enabled by PB_PORT_HUB_TIMER_EN.
module pb_port_hub
  import pb_port_hub_pkg::*;
#(
  parameter logic [7:0] BASE      = 8'h00,
  parameter int         NUM_OUT   = 4,
  parameter int         NUM_IN    = 4,
  parameter int         NUM_IRQ   = 4,
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            port_id,
  input  logic                  write_strobe,
  input  logic [7:0]            out_port,
  input  logic                  read_strobe,
  output logic [7:0]            in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  output logic [8*NUM_OUT-1:0]  out_regs,
  output logic [NUM_OUT-1:0]    out_wr,
  input  logic [8*NUM_IN-1:0]   in_data,
  output logic [NUM_IN-1:0]     in_rd,
  input  logic [NUM_IRQ-1:0]    irq_src
);

  logic                      base_hit;
  logic [5:0]                ofs;
  logic [NUM_OUT-1:0]        out_hit;
  logic [NUM_IN-1:0]         in_hit;
  logic                      hit_stat, hit_mask, hit_clr;
  logic                      hit_tlo, hit_thi;
  logic [NUM_OUT-1:0][7:0]   regs;
  logic [7:0]                rd_out, rd_in, rd_val;
  logic [7:0]                pending, mask;
  logic [7:0]                timer_lo, timer_hi;

  assign base_hit = (port_id[7:6] == BASE[7:6]);
  assign ofs      = port_id[5:0];
  assign hit_stat = base_hit && (ofs == OFS_IRQ_STATUS);
  assign hit_mask = base_hit && (ofs == OFS_IRQ_MASK);
  assign hit_clr  = base_hit && (ofs == OFS_IRQ_CLEAR);
  assign hit_tlo  = base_hit && (ofs == OFS_TIMER_LO);
  assign hit_thi  = base_hit && (ofs == OFS_TIMER_HI);
  assign out_regs = regs;

  always_comb begin
    out_hit = '0;
    rd_out  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_hit[i] = base_hit && (ofs == 6'(OFS_OUT + i));
      rd_out     = rd_out | (out_hit[i] ? regs[i] : 8'h00);
    end
  end

  always_comb begin
    in_hit = '0;
    rd_in  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_hit[i] = base_hit && (ofs == 6'(OFS_IN + i));
      rd_in     = rd_in | (in_hit[i] ? in_data[8*i +: 8] : 8'h00);
    end
  end

  // IRQ_CLEAR and unmapped offsets fall through to zero.
  always_comb begin
    rd_val = 8'h00;
    unique case (1'b1)
      |out_hit: rd_val = rd_out;
      |in_hit:  rd_val = rd_in;
      hit_stat: rd_val = pending;
      hit_mask: rd_val = mask;
      hit_tlo:  rd_val = timer_lo;
      hit_thi:  rd_val = timer_hi;
      default:  rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs    <= {NUM_OUT{OUT_RESET}};
      out_wr  <= '0;
      in_rd   <= '0;
      in_port <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (write_strobe && out_hit[i])
          regs[i] <= out_port;
      out_wr  <= write_strobe ? out_hit : '0;
      in_rd   <= read_strobe ? in_hit : '0;
      in_port <= rd_val;
    end
  end

  pb_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_src   (irq_src),
    .wdata     (out_port),
    .wr_mask   (write_strobe && hit_mask),
    .wr_clear  (write_strobe && hit_clr),
    .wr_tlo    (write_strobe && hit_tlo),
    .wr_thi    (write_strobe && hit_thi),
    .irq_ack   (interrupt_ack),
    .pending   (pending),
    .mask      (mask),
    .timer_lo  (timer_lo),
    .timer_hi  (timer_hi),
    .interrupt (interrupt)
  );

endmodule

// File: tb/tb_pb_port_hub.sv
// Directed bench for pb_port_hub (timer steps run when
// PB_PORT_HUB_TIMER_EN is defined).
module tb_pb_port_hub;

`ifdef PB_PORT_HUB_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic [7:0]  out_port;
  logic        read_strobe;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [31:0] out_regs;
  logic [3:0]  out_wr;
  logic [31:0] in_data;
  logic [3:0]  in_rd;
  logic [3:0]  irq_src;

  int checks = 0;
  int errors = 0;

  pb_port_hub #(
    .BASE      (8'h00),
    .NUM_OUT   (4),
    .NUM_IN    (4),
    .NUM_IRQ   (4),
    .OUT_RESET (8'hA5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .out_regs      (out_regs),
    .out_wr        (out_wr),
    .in_data       (in_data),
    .in_rd         (in_rd),
    .irq_src       (irq_src)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                    input string tag);
    port_id = a;
    step();
    check(tag, {24'h0, in_port}, {24'h0, exp});
  endtask

  initial begin
    reset_n = 1'b0; port_id = 8'h00; write_strobe = 1'b0;
    out_port = 8'h00; read_strobe = 1'b0; interrupt_ack = 1'b0;
    in_data = 32'h0; irq_src = 4'h0;
    repeat (3) step();
    check("rst_out_regs", out_regs, 32'hA5A5A5A5);
    check("rst_irq", {31'h0, interrupt}, 32'h0);
    check("rst_in_port", {24'h0, in_port}, 32'h0);
    check("rst_strobes", {24'h0, out_wr, in_rd}, 32'h0);
    reset_n = 1'b1;
    step();
    rd(8'h21, 8'h00, "rst_mask");

    wr(8'h02, 8'h3C);
    check("wr_regs", out_regs, 32'hA53CA5A5);
    check("wr_pulse", {28'h0, out_wr}, 32'h4);
    step();
    check("wr_pulse_end", {28'h0, out_wr}, 32'h0);
    check("rd_out2", {24'h0, in_port}, 32'h3C);
    rd(8'h07, 8'h00, "rd_beyond_out");
    rd(8'h40, 8'h00, "rd_off_base");

    in_data = 32'h11225A33;
    port_id = 8'h11;
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
    check("rd_in1", {24'h0, in_port}, 32'h5A);
    check("in_rd_pulse", {28'h0, in_rd}, 32'h2);
    step();
    check("in_rd_end", {28'h0, in_rd}, 32'h0);
    rd(8'h13, 8'h11, "rd_in3");
    rd(8'h14, 8'h00, "rd_beyond_in");

    wr(8'h21, 8'hFF);
    rd(8'h21, TEN ? 8'h8F : 8'h0F, "mask_valid_bits");
    wr(8'h21, 8'h01);

    irq_src = 4'h1;
    step();
    irq_src = 4'h0;
    check("irq_lat1", {31'h0, interrupt}, 32'h0);
    step();
    check("irq_lat2", {31'h0, interrupt}, 32'h1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    check("irq_ack_drop", {31'h0, interrupt}, 32'h0);
    irq_src = 4'h2;
    step();
    irq_src = 4'h0;
    step();
    rd(8'h20, 8'h03, "status_03");
    check("no_assert_masked", {31'h0, interrupt}, 32'h0);
    wr(8'h22, 8'h01);
    check("w1c_idle", {31'h0, interrupt}, 32'h0);
    rd(8'h20, 8'h02, "status_after_w1c");
    check("w1c_stay_low", {31'h0, interrupt}, 32'h0);
    rd(8'h22, 8'h00, "rd_clear_zero");

    irq_src = 4'h1;
    step();
    irq_src = 4'h0;
    step();
    check("irq2_assert", {31'h0, interrupt}, 32'h1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    irq_src = 4'h1;
    wr(8'h22, 8'h01);
    irq_src = 4'h0;
    check("race_rearm_low", {31'h0, interrupt}, 32'h0);
    rd(8'h20, 8'h03, "race_set_wins");
    check("race_reassert", {31'h0, interrupt}, 32'h1);

    wr(8'h21, 8'h00);
    check("mask_off_hold", {31'h0, interrupt}, 32'h1);
    step();
    check("mask_off_idle", {31'h0, interrupt}, 32'h0);

    wr(8'h21, 8'h01);
    step();
    check("reassert_pre_rst", {31'h0, interrupt}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'h0, interrupt}, 32'h0);
    check("async_rst_regs", out_regs, 32'hA5A5A5A5);
    step();
    reset_n = 1'b1;
    step();

`ifdef PB_PORT_HUB_TIMER_EN
    wr(8'h21, 8'h80);
    wr(8'h23, 8'h03);
    wr(8'h24, 8'h00);
    port_id = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      check("tmr_wait", {24'h0, in_port}, 32'h0);
    end
    step();
    check("tmr_tick1", {24'h0, in_port}, 32'h80);
    wr(8'h22, 8'h80);
    port_id = 8'h20;
    for (int i = 0; i < 2; i++) begin
      step();
      check("tmr_wait2", {24'h0, in_port}, 32'h0);
    end
    step();
    check("tmr_tick2", {24'h0, in_port}, 32'h80);
    wr(8'h23, 8'h00);
    wr(8'h22, 8'h80);
    port_id = 8'h20;
    for (int i = 0; i < 6; i++) begin
      step();
      check("tmr_stopped", {24'h0, in_port}, 32'h0);
    end
`endif

    wr(8'h23, 8'h55);
    rd(8'h23, TEN ? 8'h55 : 8'h00, "timer_lo_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
